// File: rtl/arbitro_rr_param.sv
`default_nettype none
// ============================================================================
//  Module      : arbitro_rr_param
//  Description : Parametrised NUM_CH-input / NUM_CH-output word router.
//                Each cycle, at most one word is popped from a non-empty input
//                FIFO whose destination output FIFO is not almost-full. The
//                word is registered and pushed to its destination on the next
//                cycle. Arbitration is either fixed priority or round-robin.
//                A status FSM and a wrapping transfer counter are included.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rr_param #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 10,
    parameter int DEST_W  = 2,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_CH-1:0]        empty,
    input  logic [NUM_CH-1:0]        almostfull,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        pop,
    output logic [NUM_CH-1:0]        push,
    output logic [DATA_W-1:0]        data_out,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         xfer_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Per-channel head decode and eligibility
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_word [NUM_CH];
    logic [DEST_W-1:0] w_dest [NUM_CH];
    logic [NUM_CH-1:0] w_elig;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
            assign w_word[gi] = data_in[gi*DATA_W +: DATA_W];
            assign w_dest[gi] = w_word[gi][DATA_W-1 -: DEST_W];
            // Only the head's own destination can block this channel.
            assign w_elig[gi] = !empty[gi] && !almostfull[w_dest[gi]];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [DEST_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]   push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [DEST_W-1:0]   w_start;
    logic [DEST_W-1:0]   w_scan;
    logic                w_gnt_vld;
    logic [DEST_W-1:0]   w_gnt_idx;
    logic [DATA_W-1:0]   w_gnt_word;

    // Fixed priority is a round-robin scan that always starts at channel 0.
    assign w_start = (RR_MODE != 0) ? rr_ptr_q : '0;

    // Scan channels from the start index upward (modulo NUM_CH); first eligible wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // NUM_CH is a power of two, so the DEST_W-bit add wraps naturally.
            w_scan = w_start + DEST_W'(k);
            if (!w_gnt_vld && w_elig[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    assign w_gnt_word = w_word[w_gnt_idx];

    // One-hot read enable; forced low while reset is held so FIFOs see no pops.
    always_comb begin
        pop = '0;
        if (reset_L && w_gnt_vld) begin
            pop[w_gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline next-state: registered word, destination push, pointer, counter
    // ------------------------------------------------------------------
    // Compute the values loaded at the edge that completes a pop.
    always_comb begin
        push_d   = '0;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (w_gnt_vld) begin
            push_d[w_dest[w_gnt_idx]] = 1'b1;
            data_d   = w_gnt_word;
            rr_ptr_d = w_gnt_idx + DEST_W'(1);
            // The counter advances together with push so that it already
            // includes the word being presented on the output.
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_q   <= '0;
            data_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            push_q   <= push_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Status FSM
    // ------------------------------------------------------------------
    // Next state depends only on this cycle's inputs; every transition is legal.
    always_comb begin
        state_d = state_q;
        if (w_gnt_vld) begin
            state_d = ST_ACTIVE;
        end else if (!(&empty)) begin
            state_d = ST_BLOCKED;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign push     = push_q;
    assign data_out = data_q;
    assign state    = state_q;
    assign xfer_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbitro_rr_param
//  Description : Self-checking bench for arbitro_rr_param. Two instances run
//                side by side: round-robin with a 4-bit counter, and fixed
//                priority with a 16-bit counter. Input FIFOs are modelled as
//                circular buffers; expected outputs are queued per cycle and
//                compared by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr_param;

    localparam int NCH   = 4;
    localparam int DW    = 10;
    localparam int DSTW  = 2;
    localparam int CW0   = 4;
    localparam int CW1   = 16;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [NCH-1:0]    af;
    logic [NCH-1:0]    emp0, emp1;
    logic [NCH*DW-1:0] din0, din1;
    logic [NCH-1:0]    pop0, pop1, push0, push1;
    logic [DW-1:0]     dout0, dout1;
    logic [1:0]        st0, st1;
    logic [CW0-1:0]    cnt0;
    logic [CW1-1:0]    cnt1;

    always #5 clk = ~clk;

    arbitro_rr_param #(.NUM_CH(NCH), .DATA_W(DW), .DEST_W(DSTW), .RR_MODE(1), .CNT_W(CW0)) u_rr (
        .clk(clk), .reset_L(reset_L), .empty(emp0), .almostfull(af), .data_in(din0),
        .pop(pop0), .push(push0), .data_out(dout0), .state(st0), .xfer_cnt(cnt0));

    arbitro_rr_param #(.NUM_CH(NCH), .DATA_W(DW), .DEST_W(DSTW), .RR_MODE(0), .CNT_W(CW1)) u_fp (
        .clk(clk), .reset_L(reset_L), .empty(emp1), .almostfull(af), .data_in(din1),
        .pop(pop1), .push(push1), .data_out(dout1), .state(st1), .xfer_cnt(cnt1));

    // Reference model state
    logic [DW-1:0] mem [2][NCH][DEPTH];
    int            rd  [2][NCH];
    int            occ [2][NCH];
    int            mrr [2];
    int            mcnt[2];
    logic [DW-1:0] mdout[2];
    int            gnt [2];

    typedef struct {
        int             cyc;
        int             u;
        logic [NCH-1:0] push;
        logic [DW-1:0]  data;
        int             cnt;
        int             st;
    } exp_t;
    exp_t sb[$];

    int cyc   = 0;
    int nchk  = 0;
    int nerr  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [DW-1:0] head(input int u, input int ch);
        return mem[u][ch][rd[u][ch]];
    endfunction

    task automatic append(input int u, input int ch, input logic [DW-1:0] w);
        if (occ[u][ch] < DEPTH) begin
            mem[u][ch][(rd[u][ch] + occ[u][ch]) % DEPTH] = w;
            occ[u][ch]++;
        end
    endtask

    task automatic flush_model();
        for (int u = 0; u < 2; u++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                rd[u][ch]  = 0;
                occ[u][ch] = 0;
            end
            mrr[u]   = 0;
            mcnt[u]  = 0;
            mdout[u] = '0;
            gnt[u]   = -1;
        end
        sb.delete();
    endtask

    // Present FIFO heads and empty flags to both instances.
    task automatic drive();
        logic [NCH-1:0]    e;
        logic [NCH*DW-1:0] d;
        for (int u = 0; u < 2; u++) begin
            e = '0;
            d = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                e[ch] = (occ[u][ch] == 0);
                if (occ[u][ch] != 0) d[ch*DW +: DW] = head(u, ch);
            end
            if (u == 0) begin emp0 = e; din0 = d; end
            else        begin emp1 = e; din1 = d; end
        end
    endtask

    // Spec rule: first non-empty channel whose head's destination is not
    // almost-full, scanning from the pointer (RR) or from 0 (fixed).
    function automatic int model_grant(input int u);
        int start;
        int ch;
        logic [DW-1:0] w;
        start = (u == 0) ? mrr[0] : 0;
        for (int k = 0; k < NCH; k++) begin
            ch = (start + k) % NCH;
            if (occ[u][ch] > 0) begin
                w = head(u, ch);
                if (!af[w[DW-1 -: DSTW]]) return ch;
            end
        end
        return -1;
    endfunction

    // One clock: check pop, queue expected outputs, advance FIFO model.
    task automatic step();
        exp_t           e;
        logic [NCH-1:0] oh;
        logic [DW-1:0]  w;
        int             any;
        #3;
        for (int u = 0; u < 2; u++) begin
            gnt[u] = model_grant(u);
            oh = '0;
            if (gnt[u] >= 0) oh[gnt[u]] = 1'b1;
            chk((u == 0) ? "pop_rr" : "pop_fp", (u == 0) ? pop0 : pop1, oh);
            e.cyc  = cyc + 1;
            e.u    = u;
            e.push = '0;
            if (gnt[u] >= 0) begin
                w = head(u, gnt[u]);
                e.push[w[DW-1 -: DSTW]] = 1'b1;
                mdout[u] = w;
                mcnt[u]  = (mcnt[u] + 1) % (1 << ((u == 0) ? CW0 : CW1));
                if (u == 0) mrr[0] = (gnt[u] + 1) % NCH;
                e.st = 1;
            end else begin
                any = 0;
                for (int ch = 0; ch < NCH; ch++) if (occ[u][ch] > 0) any = 1;
                e.st = any ? 2 : 0;
            end
            e.data = mdout[u];
            e.cnt  = mcnt[u];
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int u = 0; u < 2; u++) begin
            if (gnt[u] >= 0) begin
                rd[gnt[u]] = rd[gnt[u]];
                rd[u][gnt[u]]  = (rd[u][gnt[u]] + 1) % DEPTH;
                occ[u][gnt[u]] = occ[u][gnt[u]] - 1;
            end
        end
        drive();
    endtask

    // Monitor: compare registered outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.u == 0) begin
                    chk("push_rr",  push0, e.push);
                    chk("dout_rr",  dout0, e.data);
                    chk("cnt_rr",   cnt0,  e.cnt);
                    chk("state_rr", st0,   e.st);
                end else begin
                    chk("push_fp",  push1, e.push);
                    chk("dout_fp",  dout1, e.data);
                    chk("cnt_fp",   cnt1,  e.cnt);
                    chk("state_fp", st1,   e.st);
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_pop_rr"},  pop0,  '0);
        chk({tag, "_pop_fp"},  pop1,  '0);
        chk({tag, "_push_rr"}, push0, '0);
        chk({tag, "_push_fp"}, push1, '0);
        chk({tag, "_dout_rr"}, dout0, '0);
        chk({tag, "_dout_fp"}, dout1, '0);
        chk({tag, "_st_rr"},   st0,   '0);
        chk({tag, "_st_fp"},   st1,   '0);
        chk({tag, "_cnt_rr"},  cnt0,  '0);
        chk({tag, "_cnt_fp"},  cnt1,  '0);
    endtask

    initial begin
        logic [DW-1:0] w;
        reset_L = 1'b0;
        af      = '0;
        flush_model();
        // Reset with every input FIFO non-empty: nothing may move.
        for (int u = 0; u < 2; u++)
            for (int ch = 0; ch < NCH; ch++) append(u, ch, DW'(ch * 3 + 1));
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");

        // Routing: only ch2 holds 0x305 (dest 3).
        flush_model();
        append(0, 2, 10'h305);
        append(1, 2, 10'h305);
        drive();
        reset_L = 1'b1;
        step();
        chk("route_push", push0, 4'b1000);
        chk("route_dout", dout0, 10'h305);
        chk("route_cnt",  cnt0,  1);
        chk("route_st",   st0,   1);

        // Arbitration order: 3 words per channel, distinct destinations.
        for (int u = 0; u < 2; u++)
            for (int ch = 0; ch < NCH; ch++)
                for (int k = 0; k < 3; k++)
                    append(u, ch, {DSTW'((ch + k) % NCH), 8'(ch * 16 + k)});
        drive();
        repeat (13) step();
        chk("order_st_rr",  st0,  0);
        chk("order_cnt_rr", cnt0, 13);
        chk("order_st_fp",  st1,  0);
        chk("order_cnt_fp", cnt1, 13);

        // Per-destination backpressure.
        af = 4'b0010;
        for (int u = 0; u < 2; u++) begin
            append(u, 0, {2'd1, 8'hA0});
            append(u, 0, {2'd1, 8'hA1});
            append(u, 1, {2'd3, 8'hB0});
            append(u, 1, {2'd3, 8'hB1});
        end
        drive();
        repeat (3) step();
        chk("bp_st_rr",  st0,  2);
        chk("bp_st_fp",  st1,  2);
        chk("bp_pop_rr", pop0, '0);
        af = '0;
        step();
        chk("bp_release_push", push0, 4'b0010);
        repeat (2) step();

        // Randomised traffic with random almost-full.
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 2; u++)
                for (int ch = 0; ch < NCH; ch++)
                    if ($urandom_range(2) == 0 && occ[u][ch] < 8) begin
                        w = DW'($urandom);
                        append(u, ch, w);
                    end
            af = NCH'($urandom & $urandom);
            drive();
            step();
        end

        // Reset one cycle after a pop discards the in-flight word.
        af = '0;
        flush_model();
        append(0, 0, 10'h2AA);
        append(1, 0, 10'h2AA);
        drive();
        step();
        reset_L = 1'b0;
        flush_model();
        drive();
        #1;
        chk_reset("midrst");
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // Counter wrap: 17 transfers on a 4-bit counter.
        for (int k = 0; k < 17; k++) begin
            w = DW'($urandom);
            append(0, 0, w);
            append(1, 0, w);
        end
        drive();
        repeat (18) step();
        chk("wrap_cnt_rr", cnt0, 1);
        chk("wrap_cnt_fp", cnt1, 17);

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
